// File: rtl/alu_arbiter.sv
// Purpose: shares one ALU between NREQ requesters; round-robin grant, operand latch, result return.
// Latency: GNT at t, ALU_ACT at t+1, RES_VLD at t+3 (single word) or t+4 (mul); next GNT at RES_VLD+1.
// Backpressure: REQ held until GNT; ALU_RDY low holds issue; a silent ALU is aborted after TIMEOUT stalled cycles.
module alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NREQ-1:0]     REQ,
    input  logic [4*NREQ-1:0]   REQ_OP,
    input  logic [2*NREQ-1:0]   REQ_MOVI,
    input  logic [32*NREQ-1:0]  REQ_A,
    input  logic [32*NREQ-1:0]  REQ_B,
    input  logic [32*NREQ-1:0]  REQ_MEM,
    input  logic [32*NREQ-1:0]  REQ_IMM,
    output logic [NREQ-1:0]     GNT,
    output logic [NREQ-1:0]     RES_VLD,
    output logic [63:0]         RES_DATA,
    output logic                RES_ERR,
    output logic                BUSY,
    output logic                ALU_RST,
    output logic                ALU_ACT,
    output logic [3:0]          ALU_OP,
    output logic [1:0]          ALU_MOVI,
    output logic [31:0]         ALU_REG_A,
    output logic [31:0]         ALU_REG_B,
    output logic [31:0]         ALU_MEM,
    output logic [31:0]         ALU_IMM,
    input  logic [31:0]         ALU_DATA,
    input  logic                ALU_RDY,
    input  logic                ALU_VLD
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] OP_MUL = 4'b0010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        CAP_LO = 3'd2,
        CAP_HI = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic            win_found;
    logic            is_mul_q;
    logic            err_q;
    logic [TW-1:0]   tcnt_q;
    logic            rel_q;
    logic            grant;
    logic            stall;
    logic            to_fire;
    logic            cap_lo;
    logic            cap_hi;
    logic [3:0]      sel_op;
    logic [1:0]      sel_movi;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [31:0]     sel_mem;
    logic [31:0]     sel_imm;

    // Round-robin search: first requester after the last owner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Operand mux selecting the winner's slices.
    always_comb begin
        sel_op   = '0;
        sel_movi = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_mem  = '0;
        sel_imm  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == win_idx) begin
                sel_op   = REQ_OP[4*i +: 4];
                sel_movi = REQ_MOVI[2*i +: 2];
                sel_a    = REQ_A[32*i +: 32];
                sel_b    = REQ_B[32*i +: 32];
                sel_mem  = REQ_MEM[32*i +: 32];
                sel_imm  = REQ_IMM[32*i +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-cycle strobes; a stall on the last allowed cycle forces an error response.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        stall   = 1'b0;
        to_fire = 1'b0;
        cap_lo  = 1'b0;
        cap_hi  = 1'b0;
        GNT     = '0;
        RES_VLD = '0;
        ALU_ACT = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found && !ALU_RST) begin
                    grant        = 1'b1;
                    GNT[win_idx] = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (ALU_RDY) begin
                    ALU_ACT = 1'b1;
                    state_d = CAP_LO;
                end else begin
                    stall = 1'b1;
                end
            end
            CAP_LO: begin
                if (ALU_VLD) begin
                    cap_lo  = 1'b1;
                    state_d = is_mul_q ? CAP_HI : RESP;
                end else begin
                    stall = 1'b1;
                end
            end
            CAP_HI: begin
                if (ALU_VLD) begin
                    cap_hi  = 1'b1;
                    state_d = RESP;
                end else begin
                    stall = 1'b1;
                end
            end
            RESP: begin
                RES_VLD[ptr_q] = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (stall && (tcnt_q == TW'(TIMEOUT - 1))) begin
            to_fire = 1'b1;
            state_d = RESP;
        end
    end

    // Winner's operands and ownership, captured only on the grant cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ALU_OP    <= '0;
            ALU_MOVI  <= '0;
            ALU_REG_A <= '0;
            ALU_REG_B <= '0;
            ALU_MEM   <= '0;
            ALU_IMM   <= '0;
            ptr_q     <= PW'(NREQ - 1);
            is_mul_q  <= 1'b0;
        end else if (grant) begin
            ALU_OP    <= sel_op;
            ALU_MOVI  <= sel_movi;
            ALU_REG_A <= sel_a;
            ALU_REG_B <= sel_b;
            ALU_MEM   <= sel_mem;
            ALU_IMM   <= sel_imm;
            ptr_q     <= win_idx;
            is_mul_q  <= (sel_op == OP_MUL);
        end
    end

    // Stall counter, cleared at grant, shared by issue and both capture phases.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     tcnt_q <= '0;
        else if (grant) tcnt_q <= '0;
        else if (stall) tcnt_q <= tcnt_q + TW'(1);
    end

    // Result words and error flag; an abort returns zero data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RES_DATA <= '0;
            err_q    <= 1'b0;
        end else begin
            if (grant) err_q <= 1'b0;
            if (to_fire) begin
                RES_DATA <= '0;
                err_q    <= 1'b1;
            end else if (cap_lo) begin
                RES_DATA <= {32'h0, ALU_DATA};
            end else if (cap_hi) begin
                RES_DATA[63:32] <= ALU_DATA;
            end
        end
    end

    // ALU reset: two-flop release after RST_N, plus a one-cycle pulse on abort.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rel_q   <= 1'b1;
            ALU_RST <= 1'b1;
        end else begin
            rel_q   <= 1'b0;
            ALU_RST <= rel_q | to_fire;
        end
    end

    assign BUSY    = (state_q != IDLE);
    assign RES_ERR = (state_q == RESP) && err_q;

endmodule
